// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: serializes a captured bit pattern MSB-first, starting at
// bit len and ending at bit 0, repeating the frame reps extra times with no gap
// between frames. Then it pulses done for one cycle and returns to IDLE.
module seq_pattern_gen #(
    parameter  int W  = 8,
    localparam int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  pattern,
    input  logic [IW-1:0] len,
    input  logic [3:0]    reps,
    output logic          out,
    output logic          valid,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t        r_state;
    logic [W-1:0]  r_pat;
    logic [IW-1:0] r_len;
    logic [IW-1:0] r_idx;
    logic [3:0]    r_rep;
    logic          r_out;
    logic          r_valid;
    logic          r_busy;
    logic          r_done;

    state_t        w_state_nxt;
    logic [W-1:0]  w_pat_nxt;
    logic [IW-1:0] w_len_nxt;
    logic [IW-1:0] w_idx_nxt;
    logic [3:0]    w_rep_nxt;
    logic [IW-1:0] w_len_clamped;
    logic          w_out_nxt;
    logic          w_valid_nxt;
    logic          w_busy_nxt;
    logic          w_done_nxt;

    // State, captured operands, counters and output flops; reset aborts any frame.
    // NOTE: every register here is a plain flop, not a memory, so all of them take the async reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_pat   <= '0;
            r_len   <= '0;
            r_idx   <= '0;
            r_rep   <= '0;
            r_out   <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            r_state <= w_state_nxt;
            r_pat   <= w_pat_nxt;
            r_len   <= w_len_nxt;
            r_idx   <= w_idx_nxt;
            r_rep   <= w_rep_nxt;
            r_out   <= w_out_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state and datapath update: capture in IDLE, count down bits and frames in SHIFT.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
        w_state_nxt   = r_state;
        w_pat_nxt     = r_pat;
        w_len_nxt     = r_len;
        w_idx_nxt     = r_idx;
        w_rep_nxt     = r_rep;
        w_len_clamped = len;
        // A length index past the top bit can only arise for non power-of-2 widths.
        if (int'(len) > W - 1) begin
            w_len_clamped = IW'(W - 1);
        end
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_SHIFT;
                    w_pat_nxt   = pattern;
                    w_len_nxt   = w_len_clamped;
                    w_idx_nxt   = w_len_clamped;
                    w_rep_nxt   = reps;
                end
            end
            S_SHIFT: begin
                if (r_idx != '0) begin
                    w_idx_nxt = r_idx - 1'b1;
                end else if (r_rep != '0) begin
                    // Back-to-back repetition: reload the frame without an idle bit.
                    w_idx_nxt = r_len;
                    w_rep_nxt = r_rep - 1'b1;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state, so the flops present a pure Moore view.
    always_comb begin
        w_out_nxt   = 1'b0;
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        case (w_state_nxt)
            S_SHIFT: begin
                w_out_nxt   = w_pat_nxt[w_idx_nxt];
                w_valid_nxt = 1'b1;
                w_busy_nxt  = 1'b1;
            end
            S_DONE: begin
                w_done_nxt = 1'b1;
            end
            default: begin
                w_out_nxt = 1'b0;
            end
        endcase
    end

    assign out   = r_out;
    assign valid = r_valid;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed testbench for seq_pattern_gen: serial bit order, repetitions,
// one-bit frames, start held high, start ignored while busy, and async reset.
module tb_seq_pattern_gen;

    localparam int W  = 8;
    localparam int IW = 3;

    logic          clk;
    logic          rst;
    logic          start;
    logic [W-1:0]  pattern;
    logic [IW-1:0] len;
    logic [3:0]    reps;
    logic          out;
    logic          valid;
    logic          busy;
    logic          done;

    int n_assert = 0;
    int n_fail   = 0;

    seq_pattern_gen #(.W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .pattern (pattern),
        .len     (len),
        .reps    (reps),
        .out     (out),
        .valid   (valid),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just past the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Compare {out, valid, busy, done} against a hand-computed expectation.
    task automatic check(input string tag, input logic e_out, input logic e_valid,
                         input logic e_busy, input logic e_done);
        n_assert++;
        assert ({out, valid, busy, done} === {e_out, e_valid, e_busy, e_done})
        else begin
            n_fail++;
            $error("FAIL %s: out/valid/busy/done got %b%b%b%b required %b%b%b%b",
                   tag, out, valid, busy, done, e_out, e_valid, e_busy, e_done);
        end
    endtask

    // Check consecutive SHIFT cycles against a string of expected bits, starting with the current cycle.
    task automatic check_bits(input string tag, input string bits);
        for (int i = 0; i < bits.len(); i++) begin
            if (i > 0) cyc();
            check($sformatf("%s_bit%0d", tag, i), (bits[i] == "1"), 1'b1, 1'b1, 1'b0);
        end
    endtask

    // After the last bit: one done cycle, then IDLE.
    task automatic check_done(input string tag);
        cyc();
        check({tag, "_done"}, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc();
        check({tag, "_idle"}, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        start   = 1'b0;
        pattern = '0;
        len     = '0;
        reps    = '0;
        rst     = 1'b1;
        #1;
        rst = 1'b0;
        #2;
        check("reset_async", 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        cyc();
        check("reset_held", 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        cyc();
        check("idle_no_start", 1'b0, 1'b0, 1'b0, 1'b0);

        // Full 8-bit frame, single shot.
        pattern = 8'b1011_0101; len = 3'd7; reps = 4'd0; start = 1'b1;
        cyc();
        start = 1'b0;
        check_bits("t29", "10110101");
        check_done("t29");

        // 3-bit frame sent three times back to back; upper pattern bits must not leak.
        pattern = 8'b1010_1101; len = 3'd2; reps = 4'd2; start = 1'b1;
        cyc();
        start = 1'b0;
        check_bits("t30", "101101101");
        check_done("t30");

        // One-bit frames of bit 0, four times.
        pattern = 8'h55; len = 3'd0; reps = 4'd3; start = 1'b1;
        cyc();
        start = 1'b0;
        check_bits("t31", "1111");
        check_done("t31");

        // One-bit frame of a zero bit, twice.
        pattern = 8'hFE; len = 3'd0; reps = 4'd1; start = 1'b1;
        cyc();
        start = 1'b0;
        check_bits("t31z", "00");
        check_done("t31z");

        // Start held high; inputs change mid-frame without affecting it.
        pattern = 8'h3C; len = 3'd7; reps = 4'd0; start = 1'b1;
        cyc();
        check_bits("t32a", "001");
        cyc();
        pattern = 8'hFF; len = 3'd3; reps = 4'd5;
        check_bits("t32b", "11100");
        check_done("t32");
        len = 3'd7; reps = 4'd0;
        cyc();
        start = 1'b0;
        check_bits("t32c", "11111111");
        check_done("t32c");

        // Reset on the 4th SHIFT cycle aborts the frame; no done pulse follows.
        pattern = 8'b1011_0101; len = 3'd7; reps = 4'd1; start = 1'b1;
        cyc();
        start = 1'b0;
        check_bits("t33a", "101");
        cyc();
        check("t33_4th_bit", 1'b1, 1'b1, 1'b1, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("t33_async_clear", 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        check("t33_held1", 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        cyc();
        check("t33_no_done", 1'b0, 1'b0, 1'b0, 1'b0);
        reps = 4'd0; start = 1'b1;
        cyc();
        start = 1'b0;
        check_bits("t33b", "10110101");
        check_done("t33b");

        // Start asserted during SHIFT and DONE is ignored; timing follows (len+1)*(reps+1).
        pattern = 8'h96; len = 3'd4; reps = 4'd1; start = 1'b1;
        cyc();
        check_bits("t34", "1011010110");
        cyc();
        check("t34_done", 1'b0, 1'b0, 1'b0, 1'b1);
        start = 1'b0;
        cyc();
        check("t34_idle1", 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        check("t34_idle2", 1'b0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_pattern_gen.md
SEQ_PATTERN_GEN -- requirements
Module: seq_pattern_gen

Interface
REQ-001 Parameter: W, 8, pattern register width; the index width is clog2(W).
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: rst  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  request to begin transmission; sampled only in IDLE.
REQ-005 Port: pattern  input  W  bit pattern to serialize; captured on an accepted start.
REQ-006 Port: len  input  clog2(W)  index of the first transmitted bit; frame length is len+1 bits; captured on an accepted start.
REQ-007 Port: reps  input  4  number of extra frame repetitions (0 = send once); captured on an accepted start.
REQ-008 Port: out  output  1  serial data bit; registered.
REQ-009 Port: valid  output  1  high when out carries a pattern bit; registered.
REQ-010 Port: busy  output  1  high from the cycle after an accepted start through the last SHIFT cycle.
REQ-011 Port: done  output  1  one-cycle completion pulse; registered.

Function
REQ-012 The FSM SHALL be Moore type with states IDLE, SHIFT and DONE; all outputs SHALL be decoded from registered state only.
REQ-013 In IDLE, start=1 at a rising edge SHALL capture pattern, len and reps into internal registers, set idx=len and rep_cnt=reps, and move to SHIFT.
REQ-014 In SHIFT, outputs SHALL be out=pat_q[idx], valid=1, busy=1, done=0; the block transmits MSB-first starting at bit len.
REQ-015 In SHIFT with idx>0, each edge SHALL decrement idx by 1.
REQ-016 In SHIFT with idx=0 and rep_cnt>0, the edge SHALL reload idx=len_q, decrement rep_cnt, and stay in SHIFT with no gap cycle between frames.
REQ-017 In SHIFT with idx=0 and rep_cnt=0, the edge SHALL move the FSM to DONE.
REQ-018 In DONE, outputs SHALL be out=0, valid=0, busy=0, done=1 for exactly one cycle; the next state SHALL be IDLE unconditionally.
REQ-019 In IDLE, outputs SHALL be out=0, valid=0, busy=0, done=0.
REQ-020 Latency: with start accepted at edge k, the first bit SHALL be valid after edge k+1 and done SHALL assert after edge k+1+(len+1)*(reps+1).
REQ-021 start SHALL be ignored in SHIFT and in DONE; start held high continuously SHALL begin a new transmission only after passing through IDLE, giving one idle cycle minimum between transmissions.
REQ-022 Changes on pattern, len or reps after capture SHALL NOT affect an ongoing transmission.
REQ-023 len=0 SHALL transmit a 1-bit frame of pat_q[0], repeated reps+1 times.
REQ-024 len values of W or greater (possible only when W is not a power of 2) SHALL be clamped to W-1 at capture.
REQ-025 idx and rep_cnt SHALL never wrap; decrements SHALL occur only under the conditions in REQ-015 and REQ-016.

Reset
REQ-026 rst=0 SHALL immediately, without waiting for a clock edge, force the FSM to IDLE, clear out, valid, busy and done, and clear idx, rep_cnt and all captured registers.
REQ-027 rst asserted mid-transmission SHALL abort the transmission; no done pulse SHALL be produced for the aborted transmission.
REQ-028 After rst returns to 1, the block SHALL accept start on the first rising edge that samples start=1.

Verification
REQ-029 pattern=8'b10110101, len=7, reps=0, 1-cycle start -> out=1,0,1,1,0,1,0,1 with valid=1 for 8 cycles, then done=1 for 1 cycle, then IDLE.
REQ-030 pattern=8'bxxxxx101, len=2, reps=2 -> out=1,0,1,1,0,1,1,0,1 continuously with valid=1 for 9 cycles, then a done pulse.
REQ-031 len=0, pattern bit0=1, reps=3 -> out=1 with valid=1 for 4 cycles, then a done pulse.
REQ-032 start held high throughout and pattern changed to 8'hFF mid-frame -> the current frame is unaffected; DONE, then 1 IDLE cycle, then a new frame sends 8'hFF.
REQ-033 rst pulsed low at the 4th SHIFT cycle -> out, valid, busy and done go to 0 asynchronously, no done pulse occurs, and the next start restarts from bit len.
REQ-034 start pulses issued during SHIFT and during DONE -> ignored; bit count and done timing match REQ-020.
